// File: rtl/deadlock_detect_unit.sv
// deadlock_detect_unit: per-process deadlock monitor.
// Debounces the process blocking status, builds the transitive wait set,
// flags a wait-cycle through this process, then joins the token pass used
// to trace the cycle.
// Optional feature macro: DL_TOKEN_WATCHDOG_EN. When defined, a launched
// token that never comes back is reported on token_lost.
module deadlock_detect_unit #(
  parameter int PROC_NUM    = 4,
  parameter int MY_PROC_ID  = 0,
  parameter int DEP_NUM     = 2,
  parameter int HOLD_CYCLES = 4
`ifdef DL_TOKEN_WATCHDOG_EN
  , parameter int WATCHDOG_CYCLES = 64
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DEP_NUM-1:0]          proc_dep_vld_vec,
  input  logic [DEP_NUM-1:0]          in_dep_vld_vec,
  input  logic [DEP_NUM*PROC_NUM-1:0] in_dep_data_vec,
  output logic                        out_dep_vld,
  output logic [PROC_NUM-1:0]         out_dep_data,
  input  logic [DEP_NUM-1:0]          token_in_vec,
  output logic [DEP_NUM-1:0]          token_out_vec,
  input  logic                        dl_detect_in,
  input  logic                        origin,
  input  logic                        token_clear,
  output logic                        dl_detect_out
`ifdef DL_TOKEN_WATCHDOG_EN
  , output logic                      token_lost
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [PROC_NUM-1:0] SELF = PROC_NUM'(1) << MY_PROC_ID;

  typedef enum logic [1:0] {ST_MONITOR, ST_FROZEN, ST_HOLD} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic [PROC_NUM-1:0] dep_q;
  logic                vld_q, detect_q, detect_d, is_origin_q;
  logic                dl_q;
  logic [DEP_NUM-1:0]  tok_q;

  logic                blocked, stable, hit;
  logic [DEP_NUM-1:0]  live, live_low;
  logic [PROC_NUM-1:0] agg;

  assign blocked  = |proc_dep_vld_vec;
  assign stable   = (blk_cnt_q == CNT_W'(HOLD_CYCLES));
  assign live     = proc_dep_vld_vec & in_dep_vld_vec;
  // Token goes to the lowest-indexed live neighbour only.
  assign live_low = live & (~live + DEP_NUM'(1));

  // Merge the sets of live neighbours and spot ourselves inside any of them.
  always_comb begin
    agg = '0;
    hit = 1'b0;
    for (int i = 0; i < DEP_NUM; i++) begin
      if (live[i]) begin
        agg = agg | in_dep_data_vec[i*PROC_NUM +: PROC_NUM];
        hit = hit | in_dep_data_vec[i*PROC_NUM + MY_PROC_ID];
      end
    end
  end

  // Next-state of the saturating debounce counter and sticky detect flag.
  always_comb begin
    blk_cnt_d = '0;
    if (blocked) blk_cnt_d = stable ? blk_cnt_q : blk_cnt_q + CNT_W'(1);
    detect_d = detect_q | ((state_q == ST_MONITOR) & stable & hit);
  end

  // Debounce, dependency set and detect flag; set and flag freeze once frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_cnt_q <= '0;
      dep_q     <= '0;
      vld_q     <= 1'b0;
      detect_q  <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      vld_q     <= stable;
      detect_q  <= detect_d;
      if (state_q == ST_MONITOR) begin
        if (!blocked)    dep_q <= '0;
        else if (stable) dep_q <= SELF | agg;
      end
    end
  end

`ifdef DL_TOKEN_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            lost_q, wd_count, wd_expire;

  // Only an idle origin waiting in FROZEN accumulates; any token event restarts.
  assign wd_count  = (state_q == ST_FROZEN) & is_origin_q & ~token_clear
                     & ~(|token_in_vec) & ~origin;
  assign wd_expire = wd_count & (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1));
  assign token_lost = lost_q;

  // Watchdog on a launched token that never returns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      lost_q <= wd_expire;
      if (!wd_count || wd_expire) wd_cnt_q <= '0;
      else                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end
`endif

  // Report FSM; outputs registered from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_MONITOR;
      is_origin_q <= 1'b0;
      dl_q        <= 1'b0;
      tok_q       <= '0;
    end else begin
      dl_q  <= 1'b0;
      tok_q <= '0;
      case (state_q)
        ST_MONITOR: begin
          if (dl_detect_in) state_q <= ST_FROZEN;
          else              dl_q    <= detect_d;
        end
        default: begin
          if (token_clear) begin
            state_q     <= ST_FROZEN;
            is_origin_q <= 1'b0;
          end else if (state_q == ST_HOLD) begin
            state_q <= ST_FROZEN;
          end else if (origin) begin
            state_q     <= ST_HOLD;
            is_origin_q <= 1'b1;
            tok_q       <= live_low;
          end else if (|token_in_vec) begin
            // Arrival back at the origin closes the cycle: no forward.
            state_q <= ST_HOLD;
            dl_q    <= 1'b1;
            tok_q   <= is_origin_q ? '0 : live_low;
          end
`ifdef DL_TOKEN_WATCHDOG_EN
          else if (wd_expire) begin
            is_origin_q <= 1'b0;
          end
`endif
        end
      endcase
    end
  end

  assign out_dep_vld   = vld_q;
  assign out_dep_data  = dep_q;
  assign dl_detect_out = dl_q;
  assign token_out_vec = tok_q;

endmodule

// File: tb/tb_deadlock_detect_unit.sv
// Self-checking bench for deadlock_detect_unit (PROC_NUM=2, MY_PROC_ID=0,
// DEP_NUM=1, HOLD_CYCLES=4): directed scenarios plus a random run against
// a cycle-level behavioural model.
module tb_deadlock_detect_unit;
  localparam int HOLD = 4;
  localparam int MON = 0, FRZ = 1, HLD = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [0:0] proc_dep_vld_vec, in_dep_vld_vec, token_in_vec, token_out_vec;
  logic [1:0] in_dep_data_vec, out_dep_data;
  logic       out_dep_vld, dl_detect_in, origin, token_clear, dl_detect_out;
`ifdef DL_TOKEN_WATCHDOG_EN
  logic       token_lost;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int         m_run, m_state;
  logic       m_vld, m_det, m_orig, m_dl;
  logic [1:0] m_dep;
  logic [0:0] m_tok;

  deadlock_detect_unit #(.PROC_NUM(2), .MY_PROC_ID(0), .DEP_NUM(1), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset),
    .proc_dep_vld_vec(proc_dep_vld_vec), .in_dep_vld_vec(in_dep_vld_vec),
    .in_dep_data_vec(in_dep_data_vec), .out_dep_vld(out_dep_vld),
    .out_dep_data(out_dep_data), .token_in_vec(token_in_vec),
    .token_out_vec(token_out_vec), .dl_detect_in(dl_detect_in),
    .origin(origin), .token_clear(token_clear), .dl_detect_out(dl_detect_out)
`ifdef DL_TOKEN_WATCHDOG_EN
    , .token_lost(token_lost)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_run = 0; m_state = MON; m_vld = 0; m_det = 0; m_orig = 0;
    m_dl = 0; m_dep = 2'b00; m_tok = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    proc_dep_vld_vec = 0; in_dep_vld_vec = 0; in_dep_data_vec = 0;
    token_in_vec = 0; dl_detect_in = 0; origin = 0; token_clear = 0;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by the same edge.
  task automatic step(input logic p, input logic iv, input logic [1:0] d,
                      input logic dli, input logic org, input logic ti, input logic tc);
    logic       stable, live, n_vld, n_det, n_orig, n_dl;
    logic [1:0] n_dep;
    logic [0:0] n_tok;
    int         n_state;
    proc_dep_vld_vec = p; in_dep_vld_vec = iv; in_dep_data_vec = d;
    dl_detect_in = dli; origin = org; token_in_vec = ti; token_clear = tc;
    stable = (m_run >= HOLD);
    live   = p & iv;
    n_vld = stable; n_dep = m_dep; n_det = m_det; n_state = m_state;
    n_orig = m_orig; n_dl = 1'b0; n_tok = 1'b0;
    if (m_state == MON) begin
      if (!p) n_dep = 2'b00;
      else if (stable) n_dep = 2'b01 | (live ? d : 2'b00);
      if (stable && live && d[0]) n_det = 1'b1;
      if (dli) n_state = FRZ;
      else     n_dl = n_det;
    end else if (tc) begin
      n_state = FRZ; n_orig = 1'b0;
    end else if (m_state == HLD) begin
      n_state = FRZ;
    end else if (org) begin
      n_state = HLD; n_orig = 1'b1; n_tok = live;
    end else if (ti) begin
      n_state = HLD; n_dl = 1'b1; n_tok = m_orig ? 1'b0 : live;
    end
    m_run = p ? m_run + 1 : 0;
    @(posedge clock); #1;
    m_vld = n_vld; m_dep = n_dep; m_det = n_det; m_state = n_state;
    m_orig = n_orig; m_dl = n_dl; m_tok = n_tok;
  endtask

  task automatic test_reset();
    reset = 1'b1; #1;
    n_tests++; if (out_dep_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", out_dep_vld); end
    n_tests++; if (out_dep_data !== 2'b00) begin n_fail++; $display("FAIL reset_data: got %b want 00", out_dep_data); end
    n_tests++; if (dl_detect_out !== 1'b0) begin n_fail++; $display("FAIL reset_dl: got %b want 0", dl_detect_out); end
    n_tests++; if (token_out_vec !== 1'b0) begin n_fail++; $display("FAIL reset_tok: got %b want 0", token_out_vec); end
    apply_reset();
  endtask

  task automatic test_stable_blocking();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 2'b00, 0, 0, 0, 0);
      n_tests++; if (out_dep_vld !== 1'b0) begin n_fail++; $display("FAIL stable_early_%0d: got %b want 0", i, out_dep_vld); end
    end
    step(1, 0, 2'b00, 0, 0, 0, 0);
    n_tests++; if (out_dep_vld !== 1'b1) begin n_fail++; $display("FAIL stable_vld: got %b want 1", out_dep_vld); end
    n_tests++; if (out_dep_data !== 2'b01) begin n_fail++; $display("FAIL stable_data: got %b want 01", out_dep_data); end
    // gap at the third cycle: four fresh blocked cycles are needed again
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step((i == 2) ? 1'b0 : 1'b1, 0, 2'b00, 0, 0, 0, 0);
      n_tests++; if (out_dep_vld !== 1'b0) begin n_fail++; $display("FAIL gap_vld_%0d: got %b want 0", i, out_dep_vld); end
    end
    step(1, 0, 2'b00, 0, 0, 0, 0);
    n_tests++; if (out_dep_vld !== 1'b1) begin n_fail++; $display("FAIL gap_vld_final: got %b want 1", out_dep_vld); end
  endtask

  task automatic test_self_detect();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 2'b11, 0, 0, 0, 0);
    n_tests++; if (dl_detect_out !== 1'b0) begin n_fail++; $display("FAIL detect_early: got %b want 0", dl_detect_out); end
    step(1, 1, 2'b11, 0, 0, 0, 0);
    n_tests++; if (dl_detect_out !== 1'b1) begin n_fail++; $display("FAIL detect_set: got %b want 1", dl_detect_out); end
    n_tests++; if (out_dep_data !== 2'b11) begin n_fail++; $display("FAIL detect_data: got %b want 11", out_dep_data); end
    step(1, 1, 2'b11, 0, 0, 0, 0);
    n_tests++; if (dl_detect_out !== 1'b1) begin n_fail++; $display("FAIL detect_hold: got %b want 1", dl_detect_out); end
    step(1, 1, 2'b11, 1, 0, 0, 0);
    n_tests++; if (dl_detect_out !== 1'b0) begin n_fail++; $display("FAIL detect_frozen: got %b want 0", dl_detect_out); end
  endtask

  task automatic test_origin_launch();
    step(1, 1, 2'b11, 0, 1, 0, 0);
    n_tests++; if (token_out_vec !== 1'b1) begin n_fail++; $display("FAIL launch_tok: got %b want 1", token_out_vec); end
    n_tests++; if (dl_detect_out !== 1'b0) begin n_fail++; $display("FAIL launch_dl: got %b want 0", dl_detect_out); end
    step(1, 1, 2'b11, 0, 0, 0, 0);
    n_tests++; if (token_out_vec !== 1'b0) begin n_fail++; $display("FAIL launch_tok_drop: got %b want 0", token_out_vec); end
    step(1, 1, 2'b11, 0, 0, 0, 0);
    step(1, 1, 2'b11, 0, 0, 1, 0);
    n_tests++; if (dl_detect_out !== 1'b1) begin n_fail++; $display("FAIL return_dl: got %b want 1", dl_detect_out); end
    n_tests++; if (token_out_vec !== 1'b0) begin n_fail++; $display("FAIL return_tok: got %b want 0", token_out_vec); end
    step(1, 1, 2'b11, 0, 0, 0, 1);
  endtask

  task automatic test_forwarding();
    step(1, 1, 2'b11, 0, 0, 1, 0);
    n_tests++; if (dl_detect_out !== 1'b1) begin n_fail++; $display("FAIL fwd_dl: got %b want 1", dl_detect_out); end
    n_tests++; if (token_out_vec !== 1'b1) begin n_fail++; $display("FAIL fwd_tok: got %b want 1", token_out_vec); end
    step(1, 1, 2'b11, 0, 0, 0, 0);
    n_tests++; if (dl_detect_out !== 1'b0) begin n_fail++; $display("FAIL fwd_dl_drop: got %b want 0", dl_detect_out); end
    n_tests++; if (token_out_vec !== 1'b0) begin n_fail++; $display("FAIL fwd_tok_drop: got %b want 0", token_out_vec); end
  endtask

  task automatic test_collisions();
    step(1, 1, 2'b11, 0, 0, 1, 1);
    n_tests++; if ({dl_detect_out, token_out_vec} !== 2'b00) begin n_fail++; $display("FAIL clr_vs_tok: got %b want 00", {dl_detect_out, token_out_vec}); end
    step(1, 1, 2'b11, 0, 0, 0, 0);
    n_tests++; if ({dl_detect_out, token_out_vec} !== 2'b00) begin n_fail++; $display("FAIL clr_after: got %b want 00", {dl_detect_out, token_out_vec}); end
    step(1, 1, 2'b11, 0, 1, 1, 0);
    n_tests++; if ({dl_detect_out, token_out_vec} !== 2'b01) begin n_fail++; $display("FAIL org_vs_tok: got %b want 01", {dl_detect_out, token_out_vec}); end
    step(1, 1, 2'b11, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_report();
    step(1, 1, 2'b11, 0, 1, 0, 0);
    n_tests++; if (token_out_vec !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tok: got %b want 1", token_out_vec); end
    reset = 1'b1; #1;
    n_tests++; if ({out_dep_vld, out_dep_data, dl_detect_out, token_out_vec} !== 5'b0)
      begin n_fail++; $display("FAIL mid_reset_outs: got %b want 00000", {out_dep_vld, out_dep_data, dl_detect_out, token_out_vec}); end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 2'b00, 0, 0, 0, 0);
      n_tests++; if (out_dep_vld !== 1'b0) begin n_fail++; $display("FAIL mid_redebounce_%0d: got %b want 0", i, out_dep_vld); end
    end
    step(1, 0, 2'b00, 0, 0, 0, 0);
    n_tests++; if (out_dep_vld !== 1'b1) begin n_fail++; $display("FAIL mid_redebounce_vld: got %b want 1", out_dep_vld); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) apply_reset();
      else step($urandom_range(9) != 0, 1'($urandom_range(1)), 2'($urandom_range(3)),
                $urandom_range(29) == 0, $urandom_range(11) == 0,
                $urandom_range(5) == 0, $urandom_range(15) == 0);
      n_tests++; if (out_dep_vld !== m_vld) begin n_fail++; $display("FAIL rnd_vld@%0d: got %b want %b", i, out_dep_vld, m_vld); end
      n_tests++; if (out_dep_data !== m_dep) begin n_fail++; $display("FAIL rnd_data@%0d: got %b want %b", i, out_dep_data, m_dep); end
      n_tests++; if (dl_detect_out !== m_dl) begin n_fail++; $display("FAIL rnd_dl@%0d: got %b want %b", i, dl_detect_out, m_dl); end
      n_tests++; if (token_out_vec !== m_tok) begin n_fail++; $display("FAIL rnd_tok@%0d: got %b want %b", i, token_out_vec, m_tok); end
    end
  endtask

  initial begin
    test_reset();
    test_stable_blocking();
    test_self_detect();
    test_origin_launch();
    test_forwarding();
    test_collisions();
    test_reset_mid_report();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
